sram_coef_loader: RTL and testbench
===================================

// Module: sram_coef_loader
// PURPOSE
//  Sequencer owning the 8-bank coefficient SRAM of the FIR filter. LOAD mode: streams
//  BANKS*DEPTH coefficient words from a valid/ready source into the SRAM write port
//  (D/CADDR/WEN/CEN). RUN mode: registers the FIR datapath's 8 lookup addresses onto
//  A7..A0 and flags when Q7..Q0 are valid. Sits between the coefficient source, the
//  FIR datapath and the sram macro.
// PARAMETERS
//  DW     20   coefficient word width (SRAM D/Q width)
//  BANKS  8    number of ROM banks / read ports
//  AW     8    per-bank address width (DEPTH = 2**AW = 256)
//  BW     3    bank-select width, log2(BANKS); CADDR width = BW+AW = 11
// PORTS
//  clk       in   1          clock, all logic on posedge
//  rst_n     in   1          synchronous reset, active-low
//  start     in   1          pulse: begin (re)load from word 0
//  s_valid   in   1          coefficient word valid
//  s_data    in   DW         coefficient word
//  s_ready   out  1          loader accepts s_data this cycle
//  busy      out  1          high in LOAD or WCMP
//  done      out  1          high in RUN (SRAM fully loaded)
//  err_abort out  1          1-cycle pulse: start seen while LOAD active
//  run_en    in   1          datapath requests a lookup this cycle
//  lut_addr  in   BANKS*AW   packed lookup addresses, bank7 in MSBs
//  q_valid   out  1          SRAM Q7..Q0 hold data for the lookup 2 cycles earlier
//  A         out  BANKS*AW   packed to SRAM A7..A0
//  CADDR     out  BW+AW      SRAM write address {bank, addr}
//  D         out  DW         SRAM write data
//  WEN       out  1          SRAM write enable, active-low
//  CEN       out  1          SRAM chip enable, active-low
// BEHAVIOUR
//  - All outputs registered. Reset (rst_n=0 at posedge): state=IDLE, cnt=0, CEN=1, WEN=1,
//    D=0, CADDR=0, A=0, s_ready=0, busy=0, done=0, err_abort=0, q_valid=0; inputs ignored.
//  - States: IDLE -start-> LOAD; LOAD -final accept-> WCMP; WCMP -> RUN; RUN -start-> LOAD.
//  - LOAD: s_ready=1 (combinational from state, no backpressure). Accept = s_valid&&s_ready.
//    Accept in cycle t -> during t+1: CEN=0, WEN=0, D=s_data, CADDR=cnt; cnt++.
//    No accept in t -> CEN=1, WEN=1 in t+1, D/CADDR hold. cnt is BW+AW bits, no wrap:
//    accept at cnt=BANKS*2**AW-1 (2047) moves to WCMP, s_ready drops next cycle.
//  - WCMP: final write presented on SRAM port; s_ready=0; busy=1. Exactly one cycle.
//  - RUN: done=1, WEN=1, D=0. If run_en in t: A<=lut_addr, CEN=0 in t+1, else CEN=1, A holds.
//    q_valid = run_en delayed 2 cycles (addr reg + SRAM read); 0 on RUN entry.
//  - start in IDLE/RUN -> LOAD next cycle, cnt=0, done=0, q_valid pipe flushed to 0.
//  - start in LOAD: cnt=0, err_abort=1 for one cycle; a word accepted same cycle is
//    discarded (no write). start in WCMP: ignored (write completes, enter RUN).
//  - start has priority over s_valid and run_en. rst_n has priority over all.
// TESTING
//  1 rst_n=0 2 cycles with start=1,s_valid=1 -> CEN=WEN=1, s_ready=0, done=0, busy=0.
//  2 start, 2048 back-to-back words s_data=(7*i)%2**20 -> CADDR 0..2047 in order,
//    WEN=CEN=0 each cycle, done rises 2 cycles after last accept; then run_en with
//    A7..A0 sweeping all addrs -> Q matches model when q_valid=1.
//  3 s_valid every 3rd cycle -> CEN low only one cycle per accept, still 2048 writes,
//    last CADDR=2047.
//  4 start asserted after word 100 accepted -> err_abort 1-cycle pulse, next write CADDR=0.
//  5 rst_n=0 at word 500 -> IDLE next cycle, CEN=WEN=1; subsequent start writes from 0.
//  6 RUN: run_en pattern 1,0,1,1 -> CEN 0,1,0,0 one cycle later, q_valid 1,0,1,1 two
//    later; start in RUN -> done=0 and q_valid=0 next cycle, s_ready=1.

Source files
------------

// File: rtl/sram_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : sram_coef_loader
// Brief    : Streams FIR coefficients into the 8-bank SRAM, then registers the
//            datapath's lookup addresses onto the SRAM read ports.
// Revision : 1.0 - initial release
// ============================================================================
module sram_coef_loader #(
    parameter int DW    = 20,
    parameter int BANKS = 8,
    parameter int AW    = 8,
    parameter int BW    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                s_valid,
    input  logic [DW-1:0]       s_data,
    output logic                s_ready,
    output logic                busy,
    output logic                done,
    output logic                err_abort,
    input  logic                run_en,
    input  logic [BANKS*AW-1:0] lut_addr,
    output logic                q_valid,
    output logic [BANKS*AW-1:0] A,
    output logic [BW+AW-1:0]    CADDR,
    output logic [DW-1:0]       D,
    output logic                WEN,
    output logic                CEN
);

    localparam int CW = BW + AW;
    localparam logic [CW-1:0] c_LAST_WORD = CW'(BANKS * (2 ** AW) - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_WCMP = 2'd2;
    localparam logic [1:0] c_RUN  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_rd1;
    logic                r_qv;
    logic [BANKS*AW-1:0] r_a;
    logic [CW-1:0]       r_caddr;
    logic [DW-1:0]       r_d;
    logic                r_wen;
    logic                r_cen;
    logic                w_accept;

    assign w_accept = r_ready && s_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_LOAD;
            c_LOAD:  if (!start && w_accept && (r_cnt == c_LAST_WORD)) w_state_nxt = c_WCMP;
            c_WCMP:  w_state_nxt = c_RUN;
            c_RUN:   if (start) w_state_nxt = c_LOAD;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rd1   <= 1'b0;
            r_qv    <= 1'b0;
            r_a     <= '0;
            r_caddr <= '0;
            r_d     <= '0;
            r_wen   <= 1'b1;
            r_cen   <= 1'b1;
        end else begin
            // Status flags are decoded from the next state so they stay registered
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == c_LOAD);
            r_busy  <= (w_state_nxt == c_LOAD) || (w_state_nxt == c_WCMP);
            r_done  <= (w_state_nxt == c_RUN);
            r_err   <= (r_state == c_LOAD) && start;
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
            r_rd1   <= 1'b0;
            r_qv    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) r_cnt <= '0;
                end
                c_LOAD: begin
                    if (start) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        r_cen   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_d     <= s_data;
                        r_caddr <= r_cnt;
                        if (r_cnt != c_LAST_WORD) r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_WCMP: begin
                    r_d <= '0;
                end
                c_RUN: begin
                    if (start) begin
                        r_cnt <= '0;
                    end else begin
                        // Two-stage flag: address register, then SRAM read
                        r_rd1 <= run_en;
                        r_qv  <= r_rd1;
                        if (run_en) begin
                            r_a   <= lut_addr;
                            r_cen <= 1'b0;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign s_ready   = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_abort = r_err;
    assign q_valid   = r_qv;
    assign A         = r_a;
    assign CADDR     = r_caddr;
    assign D         = r_d;
    assign WEN       = r_wen;
    assign CEN       = r_cen;

endmodule
`default_nettype wire

// File: tb/tb_sram_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_coef_loader
// Brief    : Scoreboard bench for sram_coef_loader with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_coef_loader;

    localparam int DW    = 20;
    localparam int BANKS = 8;
    localparam int AW    = 8;
    localparam int BW    = 3;
    localparam int DEPTH = 256;
    localparam int WORDS = BANKS * DEPTH;

    localparam int SG_CEN = 0, SG_WEN = 1, SG_RDY = 2, SG_BUSY = 3, SG_DONE = 4;
    localparam int SG_ERR = 5, SG_QV = 6, SG_CADDR = 7, SG_D = 8;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                s_valid;
    logic [DW-1:0]       s_data;
    logic                s_ready;
    logic                busy;
    logic                done;
    logic                err_abort;
    logic                run_en;
    logic [BANKS*AW-1:0] lut_addr;
    logic                q_valid;
    logic [BANKS*AW-1:0] A;
    logic [BW+AW-1:0]    CADDR;
    logic [DW-1:0]       D;
    logic                WEN;
    logic                CEN;

    sram_coef_loader #(.DW(DW), .BANKS(BANKS), .AW(AW), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .busy(busy), .done(done), .err_abort(err_abort),
        .run_en(run_en), .lut_addr(lut_addr), .q_valid(q_valid), .A(A),
        .CADDR(CADDR), .D(D), .WEN(WEN), .CEN(CEN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM macro: one write port, eight registered read ports
    logic [DW-1:0] sram_mem [WORDS];
    logic [DW-1:0] sram_q   [BANKS];
    always @(posedge clk) begin
        if (!CEN && !WEN) sram_mem[CADDR] <= D;
        if (!CEN && WEN)
            for (int b = 0; b < BANKS; b++)
                sram_q[b] <= sram_mem[b * DEPTH + int'(A[b*AW +: AW])];
    end

    typedef struct packed { logic [BW+AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int sig; logic [63:0] exp; string nm; } chk_t;

    wr_t                   wq[$];
    logic [BANKS*DW-1:0]   lq[$];
    chk_t                  cq[$];
    logic [DW-1:0]         ref_mem [WORDS];
    int                    n_vec = 0;
    int                    n_err = 0;
    bit                    end_req = 1'b0;

    // Monitor: the only process that compares and counts
    wr_t                 m_w;
    logic [BANKS*DW-1:0] m_l;
    logic [BANKS*DW-1:0] m_q;
    chk_t                m_c;
    logic [63:0]         m_act;
    always @(negedge clk) begin
        if (!CEN && !WEN) begin
            n_vec++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL sram_write: got CADDR=%0d D=%h, required no write", CADDR, D);
            end else begin
                m_w = wq.pop_front();
                if (CADDR !== m_w.addr || D !== m_w.data) begin
                    n_err++;
                    $display("FAIL sram_write: got CADDR=%0d D=%h, required CADDR=%0d D=%h",
                             CADDR, D, m_w.addr, m_w.data);
                end
            end
        end
        if (q_valid) begin
            n_vec++;
            for (int b = 0; b < BANKS; b++) m_q[b*DW +: DW] = sram_q[b];
            if (lq.size() == 0) begin
                n_err++;
                $display("FAIL lookup: got q_valid with Q=%h, required no lookup", m_q);
            end else begin
                m_l = lq.pop_front();
                if (m_q !== m_l) begin
                    n_err++;
                    $display("FAIL lookup: got Q=%h, required Q=%h", m_q, m_l);
                end
            end
        end
        while (cq.size() > 0) begin
            m_c = cq.pop_front();
            n_vec++;
            case (m_c.sig)
                SG_CEN:   m_act = 64'(CEN);
                SG_WEN:   m_act = 64'(WEN);
                SG_RDY:   m_act = 64'(s_ready);
                SG_BUSY:  m_act = 64'(busy);
                SG_DONE:  m_act = 64'(done);
                SG_ERR:   m_act = 64'(err_abort);
                SG_QV:    m_act = 64'(q_valid);
                SG_CADDR: m_act = 64'(CADDR);
                SG_D:     m_act = 64'(D);
                default:  m_act = '1;
            endcase
            if (m_act !== m_c.exp) begin
                n_err++;
                $display("FAIL %s: got %0h, required %0h", m_c.nm, m_act, m_c.exp);
            end
        end
        if (end_req) begin
            n_vec++;
            if (wq.size() != 0 || lq.size() != 0) begin
                n_err++;
                $display("FAIL drain: got %0d writes and %0d lookups outstanding, required 0 and 0",
                         wq.size(), lq.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required end within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sig, input logic [63:0] v, input string nm);
        chk_t c;
        c.sig = sig;
        c.exp = v;
        c.nm  = nm;
        cq.push_back(c);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk(SG_RDY, 1, "s_ready_after_start");
        chk(SG_BUSY, 1, "busy_after_start");
        chk(SG_DONE, 0, "done_after_start");
        chk(SG_ERR, 0, "err_after_start");
        chk(SG_QV, 0, "qv_after_start");
    endtask

    task automatic load(input int n, input int gap, input bit rnd);
        logic [DW-1:0] d;
        wr_t           w;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
                tick();
                chk(SG_CEN, 1, "cen_idle_gap");
            end
            d = rnd ? DW'($urandom) : DW'((7 * i) % (1 << DW));
            s_valid = 1'b1;
            s_data  = d;
            w.addr  = (BW+AW)'(i);
            w.data  = d;
            wq.push_back(w);
            ref_mem[i] = d;
            tick();
            chk(SG_CEN, 0, "cen_write");
            chk(SG_WEN, 0, "wen_write");
        end
        s_valid = 1'b0;
    endtask

    task automatic finish_load();
        chk(SG_RDY, 0, "s_ready_wcmp");
        chk(SG_BUSY, 1, "busy_wcmp");
        chk(SG_DONE, 0, "done_wcmp");
        chk(SG_CADDR, WORDS - 1, "last_caddr");
        tick();
        chk(SG_DONE, 1, "done_run");
        chk(SG_BUSY, 0, "busy_run");
        chk(SG_CEN, 1, "cen_run_entry");
        chk(SG_WEN, 1, "wen_run");
        chk(SG_D, 0, "d_run");
        chk(SG_QV, 0, "qv_run_entry");
    endtask

    task automatic lookups(input int n, input bit sweep);
        logic [BANKS*AW-1:0] la;
        logic [BANKS*DW-1:0] e;
        logic [AW-1:0]       ab;
        bit                  en;
        for (int k = 0; k < n; k++) begin
            en = sweep ? 1'b1 : ($urandom_range(0, 1) == 1);
            for (int b = 0; b < BANKS; b++) begin
                ab = sweep ? AW'(k + 37 * b) : AW'($urandom);
                la[b*AW +: AW] = ab;
                e[b*DW +: DW]  = ref_mem[b * DEPTH + int'(ab)];
            end
            run_en   = en;
            lut_addr = la;
            if (en) lq.push_back(e);
            tick();
            chk(SG_CEN, 64'(!en), "cen_lookup");
        end
        run_en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int pat [4] = '{1, 0, 1, 1};
        bit en;
        logic [BANKS*AW-1:0] la;
        logic [BANKS*DW-1:0] e;

        rst_n = 1'b0; start = 1'b1; s_valid = 1'b1; s_data = '1;
        run_en = 1'b1; lut_addr = '1;
        repeat (2) begin
            tick();
            chk(SG_CEN, 1, "reset_cen");
            chk(SG_WEN, 1, "reset_wen");
            chk(SG_RDY, 0, "reset_s_ready");
            chk(SG_DONE, 0, "reset_done");
            chk(SG_BUSY, 0, "reset_busy");
        end
        rst_n = 1'b1; start = 1'b0; s_valid = 1'b0; run_en = 1'b0;
        tick();
        chk(SG_BUSY, 0, "idle_busy");
        chk(SG_RDY, 0, "idle_s_ready");

        // Full back-to-back load, address sweep, random lookups
        do_start();
        load(WORDS, 0, 1'b0);
        finish_load();
        lookups(DEPTH, 1'b1);
        lookups(200, 1'b0);

        // Sparse source: one word every third cycle
        do_start();
        load(WORDS, 2, 1'b1);
        finish_load();
        lookups(100, 1'b0);

        // Restart during load after word 100
        do_start();
        load(101, 0, 1'b1);
        start = 1'b1; s_valid = 1'b1; s_data = DW'($urandom);
        tick();
        start = 1'b0; s_valid = 1'b0;
        chk(SG_ERR, 1, "err_abort_pulse");
        chk(SG_CEN, 1, "abort_no_write");
        chk(SG_RDY, 1, "abort_s_ready");
        tick();
        chk(SG_ERR, 0, "err_abort_clear");
        load(WORDS, 0, 1'b1);
        finish_load();
        lookups(100, 1'b0);

        // Reset in the middle of a load
        do_start();
        load(500, 0, 1'b1);
        rst_n = 1'b0; s_valid = 1'b1; start = 1'b1;
        tick();
        rst_n = 1'b1; s_valid = 1'b0; start = 1'b0;
        chk(SG_CEN, 1, "midreset_cen");
        chk(SG_WEN, 1, "midreset_wen");
        chk(SG_BUSY, 0, "midreset_busy");
        chk(SG_RDY, 0, "midreset_s_ready");
        tick();
        chk(SG_BUSY, 0, "midreset_idle");
        do_start();
        load(WORDS, 0, 1'b1);
        finish_load();

        // Lookup pattern 1,0,1,1 and restart from RUN
        run_en = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            en = (k < 4) ? (pat[k] == 1) : 1'b0;
            for (int b = 0; b < BANKS; b++) begin
                la[b*AW +: AW] = AW'($urandom);
                e[b*DW +: DW]  = ref_mem[b * DEPTH + int'(la[b*AW +: AW])];
            end
            run_en = en; lut_addr = la;
            if (en) lq.push_back(e);
            tick();
            chk(SG_CEN, 64'(!en), "cen_pattern");
            if (k >= 1) chk(SG_QV, 64'((k - 1 < 4) ? pat[k-1] : 0), "qv_pattern");
        end
        run_en = 1'b1;
        tick();
        chk(SG_CEN, 0, "cen_before_restart");
        start = 1'b1; run_en = 1'b1;
        tick();
        start = 1'b0; run_en = 1'b0;
        chk(SG_DONE, 0, "restart_done");
        chk(SG_QV, 0, "restart_qv_flush");
        chk(SG_RDY, 1, "restart_s_ready");
        chk(SG_CEN, 1, "restart_cen");
        tick();
        chk(SG_QV, 0, "restart_qv_stays_low");
        repeat (3) tick();
        end_req = 1'b1;
    end

endmodule
`default_nettype wire
